// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op codes, FSM states and command layout for the ALU sequencer
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;
    localparam logic [2:0] OP_UP   = 3'b101;
    localparam logic [2:0] OP_DOWN = 3'b110;
    localparam logic [2:0] OP_MUL2 = 3'b111;
    localparam int CMD_W = 11;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic [3:0] in1;
        logic [3:0] in2;
        logic [2:0] op;
    } cmd_t;
endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// sync_cmd_fifo: synchronous command FIFO; full is registered so a same-cycle pop never frees a slot early
module sync_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = (do_push && !do_pop) ? count_q + 1'b1 :
                  (do_pop && !do_push) ? count_q - 1'b1 : count_q;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, issues each with a one-cycle load and returns the captured result
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_in1,
    input  logic [3:0]             cmd_in2,
    input  logic [2:0]             cmd_op,
    output logic [3:0]             alu_in1,
    output logic [3:0]             alu_in2,
    output logic [2:0]             alu_s,
    output logic                   alu_ld,
    input  logic [7:0]             alu_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_data,
    output logic [2:0]             rsp_op,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    state_t      state_q, state_d;
    cmd_t        op_q, op_d, head;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic        full, empty, pop;
    assign cmd_ready = !full;
    assign pop       = state_q == IDLE && !empty;
    assign alu_ld    = state_q == ISSUE;
    assign alu_in1   = op_q.in1;
    assign alu_in2   = op_q.in2;
    assign alu_s     = op_q.op;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    sync_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   ({cmd_in1, cmd_in2, cmd_op}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    // sequencing FSM: fetch, strobe, wait with operands held, then hand the result out
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    op_d    = head;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(WAIT_CYCLES);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    rsp_data_d  = alu_out;
                    rsp_op_d    = op_q.op;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios against a simple registered ALU model
module tb_alu_op_sequencer;
    logic       clk = 0;
    logic       rst = 1;
    logic       cmd_valid = 0;
    logic       cmd_ready;
    logic [3:0] cmd_in1 = 0, cmd_in2 = 0;
    logic [2:0] cmd_op = 0;
    logic [3:0] alu_in1, alu_in2;
    logic [2:0] alu_s;
    logic       alu_ld;
    logic [7:0] alu_out = 0;
    logic       rsp_valid;
    logic       rsp_ready = 0;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic       busy;
    logic [2:0] fifo_count;
    int total = 0;
    int bad = 0;

    alu_op_sequencer #(.DEPTH(4), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_op(cmd_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_s(alu_s), .alu_ld(alu_ld),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [4:0] r;
        case (s)
            3'b000: r = {1'b0, a} + {1'b0, b};
            3'b001: r = {1'b0, a} - {1'b0, b};
            3'b010, 3'b101: r = {1'b0, a} + 5'd1;
            3'b011, 3'b110: r = {1'b0, a} - 5'd1;
            3'b100: r = {4'b0, a == b};
            default: r = {a, 1'b0};
        endcase
        return {3'b0, r};
    endfunction

    always @(posedge clk) if (alu_ld) alu_out <= alu_f(alu_in1, alu_in2, alu_s);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        cmd_in1 = a;
        cmd_in2 = b;
        cmd_op = s;
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if ({alu_ld, busy} !== 2'b00) begin bad++; $display("FAIL reset_ld_busy got=%b want=00", {alu_ld, busy}); end
        total++; if ({rsp_data, rsp_op, alu_in1, alu_in2, alu_s} !== 22'd0) begin bad++; $display("FAIL reset_regs got=%h want=0", {rsp_data, rsp_op, alu_in1, alu_in2, alu_s}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_single_add();
        int n = 0, lds = 0;
        rsp_ready = 1;
        push(4'd5, 4'd3, 3'b000);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL add_count got=%0d want=1", fifo_count); end
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
            if (alu_ld) begin
                lds++;
                total++; if ({alu_in1, alu_in2, alu_s} !== {4'd5, 4'd3, 3'b000}) begin bad++; $display("FAIL add_operands got=%h want=%h", {alu_in1, alu_in2, alu_s}, {4'd5, 4'd3, 3'b000}); end
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL add_latency got=%0d want=3", n); end
        total++; if (lds !== 1) begin bad++; $display("FAIL add_ld_pulses got=%0d want=1", lds); end
        total++; if (rsp_data !== 8'h08) begin bad++; $display("FAIL add_data got=%h want=08", rsp_data); end
        total++; if (rsp_op !== 3'b000) begin bad++; $display("FAIL add_op got=%b want=000", rsp_op); end
        tick();
        total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL add_done got=%b want=00", {rsp_valid, busy}); end
    endtask

    task automatic test_order();
        bit ok;
        rsp_ready = 1;
        push(4'd9, 4'd8, 3'b000);
        push(4'hC, 4'd0, 3'b111);
        wait_rsp(20, ok);
        total++; if ({ok, rsp_data, rsp_op} !== {1'b1, 8'h11, 3'b000}) begin bad++; $display("FAIL order_first got=%h want=%h", {ok, rsp_data, rsp_op}, {1'b1, 8'h11, 3'b000}); end
        tick();
        wait_rsp(20, ok);
        total++; if ({ok, rsp_data, rsp_op} !== {1'b1, 8'h18, 3'b111}) begin bad++; $display("FAIL order_second got=%h want=%h", {ok, rsp_data, rsp_op}, {1'b1, 8'h18, 3'b111}); end
        tick();
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        bit ok, rdy;
        rsp_ready = 0;
        for (int k = 0; k < 10; k++) begin
            rdy = cmd_ready;
            cmd_in1 = 4'(acc + 2);
            cmd_in2 = 4'd1;
            cmd_op = 3'b000;
            cmd_valid = 1;
            tick();
            if (rdy) acc++;
        end
        cmd_valid = 0;
        total++; if (acc !== 5) begin bad++; $display("FAIL fill_accepted got=%0d want=5", acc); end
        total++; if ({cmd_ready, fifo_count} !== {1'b0, 3'd4}) begin bad++; $display("FAIL fill_full got=%h want=%h", {cmd_ready, fifo_count}, {1'b0, 3'd4}); end
        total++; if (alu_ld !== 1'b0) begin bad++; $display("FAIL fill_no_ld got=%b want=0", alu_ld); end
        rsp_ready = 1;
        for (int j = 0; j < 5; j++) begin
            wait_rsp(20, ok);
            total++; if ({ok, rsp_data} !== {1'b1, 8'(j + 3)}) begin bad++; $display("FAIL drain_%0d got=%h want=%h", j, {ok, rsp_data}, {1'b1, 8'(j + 3)}); end
            tick();
        end
        total++; if ({fifo_count, busy} !== 4'd0) begin bad++; $display("FAIL drain_empty got=%h want=0", {fifo_count, busy}); end
    endtask

    task automatic test_push_pop_same();
        bit ok;
        rsp_ready = 0;
        push(4'd1, 4'd1, 3'b000);
        wait_rsp(20, ok);
        push(4'd3, 4'd3, 3'b000);
        push(4'd4, 4'd4, 3'b000);
        total++; if ({ok, fifo_count, rsp_data} !== {1'b1, 3'd2, 8'h02}) begin bad++; $display("FAIL pp_setup got=%h want=%h", {ok, fifo_count, rsp_data}, {1'b1, 3'd2, 8'h02}); end
        rsp_ready = 1;
        tick();
        push(4'd5, 4'd5, 3'b000);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_count got=%0d want=2", fifo_count); end
        total++; if ({alu_ld, alu_in1} !== {1'b1, 4'd3}) begin bad++; $display("FAIL pp_oldest got=%h want=%h", {alu_ld, alu_in1}, {1'b1, 4'd3}); end
        for (int j = 0; j < 3; j++) begin
            wait_rsp(20, ok);
            total++; if ({ok, rsp_data} !== {1'b1, 8'(6 + 2 * j)}) begin bad++; $display("FAIL pp_rsp_%0d got=%h want=%h", j, {ok, rsp_data}, {1'b1, 8'(6 + 2 * j)}); end
            tick();
        end
    endtask

    task automatic test_stall();
        bit ok;
        rsp_ready = 0;
        push(4'd7, 4'd6, 3'b000);
        push(4'd5, 4'd0, 3'b111);
        wait_rsp(20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_rsp got=%b want=1", ok); end
        for (int k = 0; k < 4; k++) begin
            total++; if ({rsp_valid, rsp_data, rsp_op, alu_ld} !== {1'b1, 8'h0D, 3'b000, 1'b0}) begin bad++; $display("FAIL stall_hold_%0d got=%h want=%h", k, {rsp_valid, rsp_data, rsp_op, alu_ld}, {1'b1, 8'h0D, 3'b000, 1'b0}); end
            tick();
        end
        rsp_ready = 1;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", rsp_valid); end
        tick();
        total++; if ({alu_ld, alu_s, alu_in1} !== {1'b1, 3'b111, 4'd5}) begin bad++; $display("FAIL stall_next_issue got=%h want=%h", {alu_ld, alu_s, alu_in1}, {1'b1, 3'b111, 4'd5}); end
        wait_rsp(20, ok);
        total++; if ({ok, rsp_data, rsp_op} !== {1'b1, 8'h0A, 3'b111}) begin bad++; $display("FAIL stall_next_rsp got=%h want=%h", {ok, rsp_data, rsp_op}, {1'b1, 8'h0A, 3'b111}); end
        tick();
    endtask

    task automatic test_reset_midflight();
        bit ok;
        rsp_ready = 1;
        push(4'd2, 4'd2, 3'b000);
        push(4'd6, 4'd1, 3'b001);
        push(4'd7, 4'd0, 3'b010);
        total++; if ({busy, alu_ld, fifo_count} !== {1'b1, 1'b0, 3'd2}) begin bad++; $display("FAIL mid_wait_state got=%h want=%h", {busy, alu_ld, fifo_count}, {1'b1, 1'b0, 3'd2}); end
        rst = 1;
        tick();
        rst = 0;
        total++; if ({rsp_valid, fifo_count, alu_ld, busy} !== 6'd0) begin bad++; $display("FAIL mid_reset got=%h want=0", {rsp_valid, fifo_count, alu_ld, busy}); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h want=00", rsp_data); end
        push(4'd1, 4'd1, 3'b000);
        wait_rsp(20, ok);
        total++; if ({ok, rsp_data, rsp_op} !== {1'b1, 8'h02, 3'b000}) begin bad++; $display("FAIL mid_after got=%h want=%h", {ok, rsp_data, rsp_op}, {1'b1, 8'h02, 3'b000}); end
        tick();
        total++; if ({busy, fifo_count} !== 4'd0) begin bad++; $display("FAIL mid_idle got=%h want=0", {busy, fifo_count}); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_order();
        test_fill_drain();
        test_push_pop_same();
        test_stall();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
